// File: rtl/dmem_byte_bridge_pkg.sv
// dmem_byte_bridge_pkg: shared state encodings and helpers for the CPU-to-SRAM byte bridge
package dmem_byte_bridge_pkg;
  localparam logic [1:0] DBB_IDLE   = 2'd0;
  localparam logic [1:0] DBB_ACCESS = 2'd1;
  localparam logic [1:0] DBB_DRAIN  = 2'd2;
  localparam logic [1:0] DBB_DONE   = 2'd3;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/dmem_byte_bridge_if.sv
// dmem_byte_bridge_if: CPU data-port and SRAM pin bundle for the byte bridge
interface dmem_byte_bridge_if #(parameter int ADDR_W = 20);
  import dmem_byte_bridge_pkg::*;
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_data_i;
  logic [31:0]       mem_data_o;
  logic              stallreq_o;
  logic              sram_ce_o;
  logic              sram_we_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [7:0]        sram_wdata_o;
  logic [7:0]        sram_rdata_i;
  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, sram_rdata_i,
    input  mem_data_o, stallreq_o, sram_ce_o, sram_we_o, sram_addr_o, sram_wdata_o
  );
  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, sram_rdata_i,
    output mem_data_o, stallreq_o, sram_ce_o, sram_we_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/dmem_byte_bridge_lane_pick.sv
// dmem_lane_pick: picks the highest still-pending byte lane of a 4-bit mask
module dmem_lane_pick
  import dmem_byte_bridge_pkg::*;
(
  input  logic [3:0] mask,
  output logic [1:0] lane,
  output logic [1:0] off,
  output logic       valid
);
  // lane 3 is byte offset 0, so the highest lane goes out first
  always_comb begin
    lane  = mask[3] ? 2'd3 : mask[2] ? 2'd2 : mask[1] ? 2'd1 : 2'd0;
    off   = ~lane;
    valid = |mask;
  end
endmodule

// File: rtl/dmem_byte_bridge.sv
// dmem_byte_bridge: serves 32-bit CPU data accesses as byte-serial SRAM cycles, stalling the pipeline
module dmem_byte_bridge
  import dmem_byte_bridge_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input logic clk,
  input logic rst,
  dmem_byte_bridge_if.slave bus
);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-3:0] waddr_q, waddr_d;
  logic [3:0]        mask_q, mask_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              cap_q, cap_d;
  logic [1:0]        cap_lane_q, cap_lane_d;
  logic [1:0]        lane, off;
  logic              pick_v, accept, strobe;
  logic              unused_addr;
  assign unused_addr = ^{bus.mem_addr_i[31:ADDR_W], bus.mem_addr_i[1:0]};
  dmem_lane_pick u_pick (
    .mask  (mask_q),
    .lane  (lane),
    .off   (off),
    .valid (pick_v)
  );
  // request acceptance, lane walking and one-cycle-late read byte capture
  always_comb begin
    accept     = state_q == DBB_IDLE && bus.mem_ce_i && bus.mem_sel_i != 4'b0000;
    strobe     = state_q == DBB_ACCESS && pick_v;
    state_d    = state_q;
    waddr_d    = waddr_q;
    mask_d     = mask_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cap_d      = strobe && !we_q;
    cap_lane_d = lane;
    if (cap_q) rdata_d[{cap_lane_q, 3'b000} +: 8] = bus.sram_rdata_i;
    if (accept) begin
      state_d = DBB_ACCESS;
      waddr_d = bus.mem_addr_i[ADDR_W-1:2];
      mask_d  = bus.mem_sel_i;
      we_d    = bus.mem_we_i;
      wdata_d = bus.mem_data_i;
      rdata_d = bus.mem_we_i ? rdata_q : ZERO_WORD;
    end
    if (strobe) begin
      mask_d  = mask_q & ~(4'b0001 << lane);
      state_d = mask_d != 4'b0000 ? DBB_ACCESS : we_q ? DBB_DONE : DBB_DRAIN;
    end
    if (state_q == DBB_DRAIN) state_d = DBB_DONE;
    if (state_q == DBB_DONE) state_d = DBB_IDLE;
  end
  // CPU stall and SRAM pin drive; SRAM pins are idle-low outside ACCESS
  always_comb begin
    bus.stallreq_o   = accept || state_q == DBB_ACCESS || state_q == DBB_DRAIN;
    bus.sram_ce_o    = strobe;
    bus.sram_we_o    = strobe && we_q;
    bus.sram_addr_o  = strobe ? {waddr_q, off} : '0;
    bus.sram_wdata_o = strobe ? lane_byte(wdata_q, lane) : 8'h00;
    bus.mem_data_o   = rdata_q;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DBB_IDLE;
      waddr_q    <= '0;
      mask_q     <= 4'b0000;
      we_q       <= 1'b0;
      wdata_q    <= ZERO_WORD;
      rdata_q    <= ZERO_WORD;
      cap_q      <= 1'b0;
      cap_lane_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      mask_q     <= mask_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cap_q      <= cap_d;
      cap_lane_q <= cap_lane_d;
    end
  end
endmodule

// File: tb/tb_dmem_byte_bridge.sv
// tb_dmem_byte_bridge: randomized and directed checks of the byte bridge against a transaction-level model
module tb_dmem_byte_bridge;
  localparam int AW = 20;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_data = 32'h0;
  logic [7:0] ref_mem [int];
  logic [7:0] sram_mem [0:(1<<AW)-1];
  dmem_byte_bridge_if #(.ADDR_W(AW)) bus();
  dmem_byte_bridge #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] init_byte(input int a);
    return 8'(a ^ (a >> 8) ^ 8'h5A);
  endfunction
  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction
  // SRAM device: synchronous byte memory with one-cycle read latency
  always @(posedge clk) begin
    if (bus.sram_ce_o) begin
      if (bus.sram_we_o) sram_mem[bus.sram_addr_o] <= bus.sram_wdata_o;
      else bus.sram_rdata_i <= sram_mem[bus.sram_addr_o];
    end
  end
  task automatic drive(input logic ce, input logic we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
    bus.mem_ce_i = ce;
    bus.mem_we_i = we;
    bus.mem_addr_i = addr;
    bus.mem_sel_i = sel;
    bus.mem_data_i = data;
  endtask
  task automatic check_quiet(input string tag);
    checks++;
    if ({bus.stallreq_o, bus.sram_ce_o, bus.sram_we_o} !== 3'b000 || bus.sram_addr_o !== '0 || bus.sram_wdata_o !== 8'h00) begin
      failures++;
      $display("FAIL %s quiet: stall=%b ce=%b we=%b addr=%h wdata=%h expected all zero", tag, bus.stallreq_o, bus.sram_ce_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wdata_o);
    end
    checks++;
    if (bus.mem_data_o !== exp_data) begin
      failures++;
      $display("FAIL %s hold: mem_data_o=%h expected %h", tag, bus.mem_data_o, exp_data);
    end
  endtask
  // one full CPU transaction, checked cycle by cycle from the access rules
  task automatic run_req(input string tag, input logic we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
    int offs[$];
    int base, n, lat, a;
    logic [31:0] exp_rd, sh;
    base = int'(addr & ((32'd1 << AW) - 1) & ~32'd3);
    for (int l = 3; l >= 0; l--) if (sel[l]) offs.push_back(3 - l);
    n = offs.size();
    lat = we ? n + 1 : n + 2;
    exp_rd = 32'h0;
    for (int l = 0; l < 4; l++) if (sel[l]) exp_rd[l*8 +: 8] = ref_rd(base + 3 - l);
    drive(1'b1, we, addr, sel, data);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      checks++;
      if (bus.stallreq_o !== (c < lat)) begin
        failures++;
        $display("FAIL %s stall cyc=%0d: got %b expected %b", tag, c, bus.stallreq_o, c < lat);
      end
      if (c >= 1 && c <= n) begin
        a = base + offs[c-1];
        sh = data >> (8 * (3 - offs[c-1]));
        checks++;
        if (bus.sram_ce_o !== 1'b1 || bus.sram_we_o !== we || int'(bus.sram_addr_o) !== a || (we && bus.sram_wdata_o !== sh[7:0])) begin
          failures++;
          $display("FAIL %s strobe cyc=%0d: ce=%b we=%b addr=%h wdata=%h expected ce=1 we=%b addr=%h wdata=%h", tag, c, bus.sram_ce_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wdata_o, we, a, sh[7:0]);
        end
        if (we) ref_mem[a] = sh[7:0];
      end else begin
        checks++;
        if ({bus.sram_ce_o, bus.sram_we_o} !== 2'b00 || bus.sram_addr_o !== '0 || bus.sram_wdata_o !== 8'h00) begin
          failures++;
          $display("FAIL %s no-strobe cyc=%0d: ce=%b we=%b addr=%h wdata=%h expected zeros", tag, c, bus.sram_ce_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wdata_o);
        end
      end
      if (c == lat) begin
        if (!we) exp_data = exp_rd;
        checks++;
        if (bus.mem_data_o !== exp_data) begin
          failures++;
          $display("FAIL %s data: mem_data_o=%h expected %h", tag, bus.mem_data_o, exp_data);
        end
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask
  task automatic test_reset;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_data = 32'h0;
    check_quiet("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_directed;
    run_req("sw", 1'b1, 32'h0000_0100, 4'b1111, 32'h1122_3344);
    run_req("sb", 1'b1, 32'h0000_0202, 4'b0010, 32'hAAAA_AAAA);
    run_req("lw", 1'b0, 32'h0000_0100, 4'b1111, 32'h0);
    checks++;
    if (bus.mem_data_o !== 32'h1122_3344) begin
      failures++;
      $display("FAIL lw_value: mem_data_o=%h expected 11223344", bus.mem_data_o);
    end
    run_req("lh", 1'b0, 32'h0000_0102, 4'b0011, 32'h0);
    checks++;
    if (bus.mem_data_o !== 32'h0000_3344) begin
      failures++;
      $display("FAIL lh_value: mem_data_o=%h expected 00003344", bus.mem_data_o);
    end
  endtask
  task automatic test_idle_and_back_to_back;
    drive(1'b1, 1'b1, 32'h0000_0500, 4'b0000, 32'hDEAD_BEEF);
    repeat (3) begin
      @(negedge clk);
      check_quiet("sel_zero");
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b1, 32'h0000_0500, 4'b1111, 32'hDEAD_BEEF);
    @(negedge clk);
    check_quiet("ce_zero");
    @(posedge clk);
    #1;
    run_req("b2b_a", 1'b1, 32'h0000_0600, 4'b1111, 32'hCAFE_F00D);
    run_req("b2b_b", 1'b1, 32'h0000_0604, 4'b1001, 32'h1234_5678);
    run_req("b2b_c", 1'b0, 32'h0000_0600, 4'b0110, 32'h0);
    run_req("b2b_d", 1'b0, 32'h0000_0604, 4'b1111, 32'h0);
  endtask
  task automatic test_reset_mid;
    drive(1'b1, 1'b1, 32'h0000_0300, 4'b1111, 32'h1122_3344);
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.sram_ce_o !== 1'b1 || int'(bus.sram_addr_o) !== 32'h300) begin
      failures++;
      $display("FAIL rst_mid cyc1: ce=%b addr=%h expected ce=1 addr=00300", bus.sram_ce_o, bus.sram_addr_o);
    end
    ref_mem[32'h300] = 8'h11;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.sram_ce_o !== 1'b1 || int'(bus.sram_addr_o) !== 32'h301 || bus.sram_wdata_o !== 8'h22) begin
      failures++;
      $display("FAIL rst_mid cyc2: ce=%b addr=%h wdata=%h expected ce=1 addr=00301 wdata=22", bus.sram_ce_o, bus.sram_addr_o, bus.sram_wdata_o);
    end
    ref_mem[32'h301] = 8'h22;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_data = 32'h0;
    repeat (2) begin
      @(negedge clk);
      check_quiet("rst_mid_after");
      @(posedge clk);
      #1;
    end
    run_req("rst_mid_lw", 1'b0, 32'h0000_0300, 4'b1111, 32'h0);
    checks++;
    if (bus.mem_data_o[31:16] !== 16'h1122 || bus.mem_data_o[15:0] !== {init_byte(32'h302), init_byte(32'h303)}) begin
      failures++;
      $display("FAIL rst_mid_value: mem_data_o=%h expected 1122%h%h", bus.mem_data_o, init_byte(32'h302), init_byte(32'h303));
    end
  endtask
  task automatic test_random;
    logic [31:0] r, addr;
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      addr = (r & 32'hFFF0_0000) | (32'h400 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) begin
        drive(1'b1, 1'($urandom), addr, 4'b0000, $urandom);
        @(negedge clk);
        check_quiet("rand_idle");
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end else begin
        run_req("rand", 1'($urandom), addr, 4'($urandom_range(1, 15)), $urandom);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = init_byte(i);
    test_reset;
    test_directed;
    test_idle_and_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_byte_bridge.md
Name: dmem_byte_bridge

Overview:
- Responder end of the CPU data-memory port, i.e. the side the MEM stage drives with ce/we/addr/sel/data.
- Serves each CPU request against an external 8-bit synchronous SRAM, one byte lane per cycle.
- Holds the pipeline with stallreq_o until the access completes.
- Sits between the MEM stage / ctrl stall logic and the board SRAM pins.

Parameters:
ADDR_W, 20, width of the SRAM byte address; CPU address bits above ADDR_W-1 are ignored.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
mem_ce_i  input  1  CPU data-port chip enable (`ChipEnable)
mem_we_i  input  1  CPU write enable (`WriteEnable)
mem_addr_i  input  32  CPU byte address; bits [1:0] ignored, word-aligned internally
mem_sel_i  input  4  byte-lane enables; sel[3]=data[31:24]=offset 0 … sel[0]=data[7:0]=offset 3 (big-endian)
mem_data_i  input  32  CPU write data
mem_data_o  output  32  read data to CPU
stallreq_o  output  1  pipeline stall request to ctrl
sram_ce_o  output  1  SRAM strobe
sram_we_o  output  1  SRAM write enable
sram_addr_o  output  ADDR_W  SRAM byte address
sram_wdata_o  output  8  SRAM write byte
sram_rdata_i  input  8  SRAM read byte, valid 1 cycle after a read strobe

Behaviour:
- Reset (rst low at clk edge): FSM to IDLE; all outputs 0; mem_data_o = 0. Reset mid-operation aborts immediately and issues no further strobes. Bytes already written stay written.
- States: IDLE, ACCESS, DRAIN, DONE.
- IDLE:
  - mem_ce_i=1 and mem_sel_i≠0: stallreq_o=1 combinationally in the same cycle (cycle 0).
  - On that edge, latch word address, sel mask, wdata and we. On a read, clear mem_data_o. Go to ACCESS.
  - mem_ce_i=0 or sel=0: no stall, no strobe, stay IDLE.
- ACCESS:
  - Visits selected lanes from lane 3 down to lane 0, skipping unselected lanes, one lane per cycle.
  - Each cycle: sram_ce_o=1, sram_we_o=latched we, sram_addr_o={addr[ADDR_W-1:2], 2'(3-lane)}, sram_wdata_o=latched wdata byte of that lane. stallreq_o=1.
  - After the last selected lane: write goes to DONE; read goes to DRAIN.
- Reads are pipelined:
  - The byte for a lane issued in cycle k is captured from sram_rdata_i at the end of cycle k+1 into the matching byte of mem_data_o.
  - The captured lane index is carried in a 1-deep register.
  - Unselected lanes read as 0.
- DRAIN: no strobe; captures the last byte; stallreq_o=1; go to DONE.
- DONE:
  - stallreq_o=0, no strobe, mem_data_o valid.
  - Request inputs are still present (pipeline held) and must NOT be re-accepted.
  - Unconditionally go to IDLE.
- Latency, n = popcount(sel):
  - Write: stall cycles 0..n, release in cycle n+1.
  - Read: stall cycles 0..n+1, release in cycle n+2.
- Back-to-back: a new request presented the cycle after DONE is accepted from IDLE normally.
- mem_data_o holds its value across writes and idle. It changes only on read accept (clear) and on byte capture.
- Outside ACCESS, sram_* outputs are 0.
- Misaligned sel/addr combinations are not checked; the mask alone decides the lanes.

Decomposition:
- define.v gains:
  - state encodings: `DBB_IDLE, `DBB_ACCESS, `DBB_DRAIN, `DBB_DONE
  - `SramAddrBus
  - reuse of `ChipEnable, `WriteEnable, `RegBus, `ZeroWord
- One sub-module, dmem_lane_pick: combinational priority pick of the highest set lane in a 4-bit remaining-mask. Outputs lane index, offset and a valid flag.
- The FSM clears the picked bit from the remaining-mask each ACCESS cycle.

Test Plan:
1. SW: ce=1, we=1, addr=0x100, sel=1111, data=0x11223344 → SRAM writes 0x100=11, 0x101=22, 0x102=33, 0x103=44 in cycles 1–4; stallreq 1 in cycles 0–4, 0 in cycle 5.
2. SB: addr=0x202, sel=0010, data=0xAAAAAAAA → single write 0x202=AA in cycle 1; stall cycles 0–1; release cycle 2; no other strobes.
3. LW: addr=0x100 after test 1 → reads issued for 0x100–0x103 in cycles 1–4, DRAIN in cycle 5, mem_data_o=0x11223344 with stallreq 0 in cycle 6.
4. LH: addr=0x102, sel=0011 → reads 0x102, 0x103; mem_data_o=0x00003344 in cycle 4.
5. ce=1 with sel=0000 → stallreq stays 0, no SRAM strobe. Then DONE followed immediately by a new SW → accepted the next cycle with correct timing.
6. rst low at cycle 2 of the test-1 SW → next cycle all outputs 0 and FSM in IDLE; only 0x100 and 0x101 written. A subsequent LW returns 0x1122xxxx, where xxxx is the old memory contents.
